// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared JTAG engine types and default widths
//
// Holds the TDO capture state encoding and the default vector RAM / counter
// widths so that tdo_capture, its interface and neighbouring JTAG blocks agree.
package jtag_pkg;

    localparam int DEF_J_D_WIDTH = 8;   // vector RAM data width (bits per word)
    localparam int DEF_J_A_WIDTH = 12;  // vector RAM address width
    localparam int DEF_CNT_WIDTH = 16;  // bit length / bit counter width

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

endpackage

// File: rtl/tdo_capture_if.sv
// rtl/tdo_capture_if.sv - control, TDO input and vector RAM write bundle for tdo_capture
//
// master: drives capture control and TDO samples, observes RAM write and status.
// slave : the capture engine (inputs capture_start..tdo_valid, outputs the rest).
interface tdo_capture_if
    import jtag_pkg::*;
#(
    parameter int J_D_WIDTH = DEF_J_D_WIDTH,
    parameter int J_A_WIDTH = DEF_J_A_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) ();

    logic                 capture_start;
    logic                 capture_abort;
    logic [J_A_WIDTH-1:0] start_addr;
    logic [CNT_WIDTH-1:0] bit_len;
    logic                 tdo;
    logic                 tdo_valid;
    logic [J_A_WIDTH-1:0] vector_2_addr;
    logic                 vector_2_we;
    logic [J_D_WIDTH-1:0] vector_2_wr_data;
    logic                 busy;
    logic                 done;
    logic                 wrapped;
    logic [CNT_WIDTH-1:0] bit_count;

    modport master (
        output capture_start, capture_abort, start_addr, bit_len, tdo, tdo_valid,
        input  vector_2_addr, vector_2_we, vector_2_wr_data, busy, done, wrapped, bit_count
    );

    modport slave (
        input  capture_start, capture_abort, start_addr, bit_len, tdo, tdo_valid,
        output vector_2_addr, vector_2_we, vector_2_wr_data, busy, done, wrapped, bit_count
    );

endinterface

// File: rtl/tdo_capture.sv
// rtl/tdo_capture.sv - packs sampled TDO bits LSB-first into vector RAM words
//
// Ports:
//   clk   - sole clock, shared with the vector RAM write port
//   reset - synchronous active-high reset
//   bus   - tdo_capture_if.slave: capture_start/abort, start_addr, bit_len,
//           tdo/tdo_valid in; vector_2_addr/we/wr_data, busy, done, wrapped,
//           bit_count out
module tdo_capture
    import jtag_pkg::*;
#(
    parameter int J_D_WIDTH = DEF_J_D_WIDTH,
    parameter int J_A_WIDTH = DEF_J_A_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    tdo_capture_if.slave bus
);

    localparam int               POS_W    = (J_D_WIDTH > 1) ? $clog2(J_D_WIDTH) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(J_D_WIDTH - 1);

    cap_state_t           r_state;
    cap_state_t           w_next;
    logic [J_A_WIDTH-1:0] r_addr;
    logic [CNT_WIDTH-1:0] r_len;
    logic [CNT_WIDTH-1:0] r_count;
    logic [J_D_WIDTH-1:0] r_shift;
    logic [J_D_WIDTH-1:0] r_wr_data;
    logic [POS_W-1:0]     r_pos;
    logic                 r_we;
    logic                 r_wrapped;

    logic [CNT_WIDTH-1:0] w_count_inc;
    logic [J_D_WIDTH-1:0] w_word;
    logic                 w_start;
    logic                 w_abort;
    logic                 w_take;
    logic                 w_last;
    logic                 w_word_end;
    logic                 w_we;

    assign w_start     = (r_state == ST_IDLE) && bus.capture_start;
    assign w_abort     = bus.capture_abort && ((r_state == ST_CAPTURE) || (r_state == ST_FLUSH));
    // Abort beats a simultaneous TDO sample, so the bit is neither stored nor counted.
    assign w_take      = (r_state == ST_CAPTURE) && bus.tdo_valid && !bus.capture_abort;
    assign w_count_inc = r_count + CNT_WIDTH'(1);
    assign w_last      = w_take && (w_count_inc == r_len);
    assign w_word_end  = w_take && (r_pos == POS_LAST);
    // Shift register is zeroed per word, so unused high bits of a short final word stay 0.
    assign w_word      = r_shift | (J_D_WIDTH'(bus.tdo) << r_pos);
    // The write strobe is registered; reset or an abort during the final write
    // cycle must still be able to cancel the write that is already on the port.
    assign w_we        = r_we && !reset && !(w_abort && (r_state == ST_FLUSH));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.capture_start) begin
                    w_next = (bus.bit_len == '0) ? ST_DONE : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (w_abort) begin
                    w_next = ST_IDLE;
                end else if (w_last) begin
                    w_next = ST_FLUSH;
                end
            end
            ST_FLUSH: w_next = w_abort ? ST_IDLE : ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr    <= '0;
            r_len     <= '0;
            r_count   <= '0;
            r_shift   <= '0;
            r_wr_data <= '0;
            r_pos     <= '0;
            r_we      <= 1'b0;
            r_wrapped <= 1'b0;
        end else begin
            r_we <= 1'b0;
            // Address advances at the end of each write cycle that actually happened.
            if (w_we) begin
                r_addr <= r_addr + J_A_WIDTH'(1);
                if (r_addr == '1) begin
                    r_wrapped <= 1'b1;
                end
            end
            if (w_start) begin
                r_addr    <= bus.start_addr;
                r_len     <= bus.bit_len;
                r_count   <= '0;
                r_wrapped <= 1'b0;
                r_shift   <= '0;
                r_pos     <= '0;
            end else if (w_take) begin
                r_count <= w_count_inc;
                if (w_word_end || w_last) begin
                    r_we      <= 1'b1;
                    r_wr_data <= w_word;
                    r_shift   <= '0;
                    r_pos     <= '0;
                end else begin
                    r_shift <= w_word;
                    r_pos   <= r_pos + POS_W'(1);
                end
            end
        end
    end

    assign bus.vector_2_addr    = r_addr;
    assign bus.vector_2_we      = w_we;
    assign bus.vector_2_wr_data = r_wr_data;
    assign bus.busy             = (r_state == ST_CAPTURE) || (r_state == ST_FLUSH);
    assign bus.done             = (r_state == ST_DONE);
    assign bus.wrapped          = r_wrapped;
    assign bus.bit_count        = r_count;

endmodule
